// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and data access.
// Optional misaligned-address rejection is enabled by defining ARB_MISALIGN_CHK_EN.
`ifndef WIDTH
`define WIDTH 32
`endif

module mem_port_arbiter #(
  parameter int WIDTH      = `WIDTH,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic [WIDTH-1:0] if_addr,
  output logic [WIDTH-1:0] if_rdata,
  output logic             if_ready,
  input  logic             dm_req,
  input  logic             dm_we,
  input  logic [WIDTH-1:0] dm_addr,
  input  logic [WIDTH-1:0] dm_wdata,
  output logic [WIDTH-1:0] dm_rdata,
  output logic             dm_ready,
  output logic             mem_en,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             stall_fetch,
  output logic             stall_mem,
`ifdef ARB_MISALIGN_CHK_EN
  output logic             misalign,
`endif
  output logic             busy
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  localparam logic [2:0] CNT_INIT   = 3'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [3:0]       starve_q, starve_d;
  logic             owner_q, owner_d;
  logic             mem_en_q, mem_en_d;
  logic             mem_we_q, mem_we_d;
  logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [WIDTH-1:0] dm_rdata_q, dm_rdata_d;
  logic             if_ready_q, if_ready_d;
  logic             dm_ready_q, dm_ready_d;
`ifdef ARB_MISALIGN_CHK_EN
  logic             misalign_q, misalign_d;
`endif

  logic             if_elig_s;
  logic             dm_elig_s;
  logic             grant_s;
  logic             pick_dm_s;
  logic [WIDTH-1:0] sel_addr_s;
  logic             misaligned_s;
  logic [3:0]       starve_inc_s;

  // A requester whose ready is high this cycle is already served and must not be re-granted.
  assign if_elig_s    = if_req & ~if_ready_q;
  assign dm_elig_s    = dm_req & ~dm_ready_q;
  assign grant_s      = if_elig_s | dm_elig_s;
  assign pick_dm_s    = dm_elig_s & ~(if_elig_s & (starve_q == STARVE_LIM));
  assign sel_addr_s   = pick_dm_s ? dm_addr : if_addr;
  assign starve_inc_s = (starve_q == STARVE_LIM) ? STARVE_LIM : (starve_q + 4'd1);
`ifdef ARB_MISALIGN_CHK_EN
  assign misaligned_s = (sel_addr_s[1:0] != 2'b00);
`else
  assign misaligned_s = 1'b0;
`endif

  // Next-state, arbitration and access sequencing.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    starve_d    = starve_q;
    owner_d     = owner_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;
`ifdef ARB_MISALIGN_CHK_EN
    misalign_d  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
        if (grant_s) begin
          if (pick_dm_s) begin
            starve_d = if_elig_s ? starve_inc_s : 4'd0;
          end else begin
            starve_d = 4'd0;
          end
          if (misaligned_s) begin
            // Rejected without touching memory; only the owner's ready pulses.
`ifdef ARB_MISALIGN_CHK_EN
            misalign_d = 1'b1;
`endif
            if (pick_dm_s) begin
              dm_ready_d = 1'b1;
            end else begin
              if_ready_d = 1'b1;
            end
          end else begin
            state_d    = S_ACCESS;
            cnt_d      = CNT_INIT;
            owner_d    = pick_dm_s;
            mem_en_d   = 1'b1;
            mem_we_d   = pick_dm_s & dm_we;
            mem_addr_d = sel_addr_s;
            if (pick_dm_s) begin
              mem_wdata_d = dm_wdata;
            end else begin
              mem_wdata_d = mem_wdata_q;
            end
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (cnt_q == 3'd0) begin
          state_d  = S_IDLE;
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          if (owner_q) begin
            dm_ready_d = 1'b1;
            if (!mem_we_q) begin
              dm_rdata_d = mem_rdata;
            end else begin
              dm_rdata_d = dm_rdata_q;
            end
          end else begin
            if_ready_d = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      starve_q    <= 4'd0;
      owner_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {WIDTH{1'b0}};
      mem_wdata_q <= {WIDTH{1'b0}};
      if_rdata_q  <= {WIDTH{1'b0}};
      dm_rdata_q  <= {WIDTH{1'b0}};
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
`ifdef ARB_MISALIGN_CHK_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      owner_q     <= owner_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
`ifdef ARB_MISALIGN_CHK_EN
      misalign_q  <= misalign_d;
`endif
    end
  end

  assign if_rdata    = if_rdata_q;
  assign if_ready    = if_ready_q;
  assign dm_rdata    = dm_rdata_q;
  assign dm_ready    = dm_ready_q;
  assign mem_en      = mem_en_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign stall_fetch = if_req & ~if_ready_q;
  assign stall_mem   = dm_req & ~dm_ready_q;
  assign busy        = (state_q == S_ACCESS);
`ifdef ARB_MISALIGN_CHK_EN
  assign misalign    = misalign_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter (MEM_LAT=2, STARVE_MAX=3); inputs driven and
// outputs sampled on the falling edge, read data checked against queued expectations.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        stall_fetch;
  logic        stall_mem;
  logic        busy;
`ifdef ARB_MISALIGN_CHK_EN
  logic        misalign;
`endif

  int tests_run = 0;
  int fails     = 0;
  logic [31:0] if_q[$];
  logic [31:0] dm_q[$];
  logic [31:0] dm_last;

  mem_port_arbiter #(.WIDTH(32), .MEM_LAT(2), .STARVE_MAX(3)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_fetch(stall_fetch), .stall_mem(stall_mem),
`ifdef ARB_MISALIGN_CHK_EN
    .misalign(misalign),
`endif
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-only memory contents as seen at the memory port.
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    case (a)
      32'h0000_0100: mem_val = 32'h2402_000A;
      32'h0000_0200: mem_val = 32'h1111_2222;
      32'h0000_0040: mem_val = 32'hA5A5_0040;
      32'h0000_0044: mem_val = 32'h0BAD_F00D;
      32'h0000_0104: mem_val = 32'h1234_5678;
      32'h0000_0048: mem_val = 32'hCAFE_0048;
      default:       mem_val = {a[15:0], 16'hEEEE};
    endcase
  endfunction

  assign mem_rdata = mem_val(mem_addr);

  // Scoreboard: every ready pulse must match a queued expectation.
  always @(negedge clk) begin
    if (if_ready === 1'b1) begin
      tests_run++;
      if (if_q.size() == 0) begin
        fails++;
        $display("FAIL if_ready_unexpected: got pulse, expected none");
      end else begin
        logic [31:0] e;
        e = if_q.pop_front();
        if (if_rdata !== e) begin
          fails++;
          $display("FAIL if_rdata: got %h expected %h", if_rdata, e);
        end
      end
    end
    if (dm_ready === 1'b1) begin
      tests_run++;
      if (dm_q.size() == 0) begin
        fails++;
        $display("FAIL dm_ready_unexpected: got pulse, expected none");
      end else begin
        logic [31:0] e;
        e = dm_q.pop_front();
        if (dm_rdata !== e) begin
          fails++;
          $display("FAIL dm_rdata: got %h expected %h", dm_rdata, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task test_reset;
    @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if ({mem_en, mem_we, if_ready, dm_ready, busy, stall_fetch, stall_mem} !== 7'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b expected 0000000",
               {mem_en, mem_we, if_ready, dm_ready, busy, stall_fetch, stall_mem});
    end
    tests_run++;
    if ({mem_addr, mem_wdata, if_rdata, dm_rdata} !== 128'h0) begin
      fails++;
      $display("FAIL reset_data: got %h expected 0", {mem_addr, mem_wdata, if_rdata, dm_rdata});
    end
    dm_last = 32'h0;
  endtask

  task test_if_read;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100;
    if_q.push_back(32'h2402_000A);
    #1;
    tests_run++;
    if (stall_fetch !== 1'b1 || mem_en !== 1'b0) begin
      fails++;
      $display("FAIL if_read_t0: got stall=%b en=%b expected 1 0", stall_fetch, mem_en);
    end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k <= 2) begin
        tests_run++;
        if ({mem_en, mem_we, busy, stall_fetch, if_ready} !== 5'b10110 || mem_addr !== 32'h100) begin
          fails++;
          $display("FAIL if_read_access k=%0d: got en/we/busy/stall/rdy=%b addr=%h expected 10110 100",
                   k, {mem_en, mem_we, busy, stall_fetch, if_ready}, mem_addr);
        end
      end else if (k == 3) begin
        tests_run++;
        if ({if_ready, mem_en, stall_fetch, busy} !== 4'b1000) begin
          fails++;
          $display("FAIL if_read_ready: got rdy/en/stall/busy=%b expected 1000",
                   {if_ready, mem_en, stall_fetch, busy});
        end
        if_req = 1'b0;
      end else begin
        tests_run++;
        if (mem_en !== 1'b0 || mem_addr !== 32'h100) begin
          fails++;
          $display("FAIL idle_hold: got en=%b addr=%h expected 0 100", mem_en, mem_addr);
        end
      end
    end
  endtask

  task test_simultaneous;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h200;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
    dm_q.push_back(32'hA5A5_0040); dm_last = 32'hA5A5_0040;
    if_q.push_back(32'h1111_2222);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1 || k == 2) begin
        tests_run++;
        if (mem_addr !== 32'h40 || mem_en !== 1'b1) begin
          fails++;
          $display("FAIL sim_data_first k=%0d: got addr=%h en=%b expected 40 1", k, mem_addr, mem_en);
        end
      end else if (k == 3) begin
        tests_run++;
        if ({dm_ready, if_ready} !== 2'b10) begin
          fails++;
          $display("FAIL sim_dm_ready: got dm/if=%b expected 10", {dm_ready, if_ready});
        end
        dm_req = 1'b0;
      end else if (k == 4 || k == 5) begin
        tests_run++;
        if (mem_addr !== 32'h200 || mem_en !== 1'b1) begin
          fails++;
          $display("FAIL sim_if_second k=%0d: got addr=%h en=%b expected 200 1", k, mem_addr, mem_en);
        end
      end else begin
        tests_run++;
        if ({if_ready, dm_ready} !== 2'b10) begin
          fails++;
          $display("FAIL sim_if_ready: got if/dm=%b expected 10", {if_ready, dm_ready});
        end
        if_req = 1'b0;
      end
    end
  endtask

  task test_store;
    @(negedge clk);
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h80; dm_wdata = 32'hDEAD_BEEF;
    dm_q.push_back(dm_last);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k <= 2) begin
        tests_run++;
        if ({mem_en, mem_we} !== 2'b11 || mem_addr !== 32'h80 || mem_wdata !== 32'hDEAD_BEEF) begin
          fails++;
          $display("FAIL store_access k=%0d: got en/we=%b addr=%h wdata=%h expected 11 80 deadbeef",
                   k, {mem_en, mem_we}, mem_addr, mem_wdata);
        end
        dm_addr = 32'h84; dm_wdata = 32'h0;
      end else begin
        tests_run++;
        if (dm_ready !== 1'b1 || mem_we !== 1'b0) begin
          fails++;
          $display("FAIL store_ready: got rdy=%b we=%b expected 1 0", dm_ready, mem_we);
        end
        dm_req = 1'b0; dm_we = 1'b0;
      end
    end
  endtask

  task test_starvation;
    for (int g = 0; g < 3; g++) begin
      @(negedge clk);
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h44;
      if_req = 1'b1; if_addr = 32'h104;
      dm_q.push_back(32'h0BAD_F00D); dm_last = 32'h0BAD_F00D;
      @(negedge clk);
      tests_run++;
      if (mem_addr !== 32'h44 || mem_en !== 1'b1) begin
        fails++;
        $display("FAIL starve_data_grant g=%0d: got addr=%h en=%b expected 44 1", g, mem_addr, mem_en);
      end
      if_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      dm_req = 1'b0;
      @(negedge clk);
    end
    dm_req = 1'b1; if_req = 1'b1;
    if_q.push_back(32'h1234_5678);
    @(negedge clk);
    tests_run++;
    if (mem_addr !== 32'h104 || mem_we !== 1'b0) begin
      fails++;
      $display("FAIL starve_forced_if: got addr=%h we=%b expected 104 0", mem_addr, mem_we);
    end
    dm_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (if_ready !== 1'b1) begin
      fails++;
      $display("FAIL starve_if_ready: got %b expected 1", if_ready);
    end
    if_req = 1'b0;
    @(negedge clk);
    dm_req = 1'b1; if_req = 1'b1;
    dm_q.push_back(32'h0BAD_F00D);
    if_q.push_back(32'h1234_5678);
    @(negedge clk);
    tests_run++;
    if (mem_addr !== 32'h44) begin
      fails++;
      $display("FAIL starve_cleared: got addr=%h expected 44", mem_addr);
    end
    @(negedge clk);
    @(negedge clk);
    dm_req = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (if_ready !== 1'b1) begin
      fails++;
      $display("FAIL starve_tail_if_ready: got %b expected 1", if_ready);
    end
    if_req = 1'b0;
  endtask

  task test_drop;
    @(negedge clk);
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h48;
    dm_q.push_back(32'hCAFE_0048); dm_last = 32'hCAFE_0048;
    @(negedge clk);
    dm_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (dm_ready !== 1'b1) begin
      fails++;
      $display("FAIL drop_ready: got %b expected 1", dm_ready);
    end
  endtask

`ifdef ARB_MISALIGN_CHK_EN
  task test_misalign;
    @(negedge clk);
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h43;
    dm_q.push_back(dm_last);
    @(negedge clk);
    tests_run++;
    if ({dm_ready, misalign, mem_en} !== 3'b110) begin
      fails++;
      $display("FAIL misalign_pulse: got rdy/mis/en=%b expected 110", {dm_ready, misalign, mem_en});
    end
    dm_req = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({misalign, busy, mem_en} !== 3'b000) begin
      fails++;
      $display("FAIL misalign_clear: got mis/busy/en=%b expected 000", {misalign, busy, mem_en});
    end
  endtask
`endif

  task test_reset_mid_access;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_busy: got %b expected 1", busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    dm_last = 32'h0;
    tests_run++;
    if ({mem_en, busy, if_ready} !== 3'b000 || if_rdata !== 32'h0) begin
      fails++;
      $display("FAIL rst_mid_abandon: got en/busy/rdy=%b rdata=%h expected 000 0",
               {mem_en, busy, if_ready}, if_rdata);
    end
    if_q.push_back(32'h2402_000A);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (if_ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_reserve: got %b expected 1", if_ready);
    end
    if_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    if_req = 1'b0; if_addr = 32'h0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'h0; dm_wdata = 32'h0;
    dm_last = 32'h0;
    repeat (3) @(negedge clk);
    test_reset;
    test_if_read;
    test_simultaneous;
    test_store;
    test_starvation;
    test_drop;
`ifdef ARB_MISALIGN_CHK_EN
    test_misalign;
`endif
    test_reset_mid_access;
    repeat (3) @(negedge clk);
    tests_run++;
    if (if_q.size() != 0 || dm_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got if=%0d dm=%0d pending expected 0 0", if_q.size(), dm_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
